// File: rtl/score_arbiter_if.sv
// score_arbiter_if: point inputs, digit-chain controls and score outputs of the arbiter
interface score_arbiter_if #(parameter int SCORE_W = 7);
  logic pt_a, pt_b, new_game;
  logic incr_a, incr_b, clear_out, game_over, winner;
  logic [SCORE_W-1:0] score_a, score_b;
  modport master (
    output pt_a, pt_b, new_game,
    input  incr_a, incr_b, clear_out, game_over, winner, score_a, score_b
  );
  modport slave (
    input  pt_a, pt_b, new_game,
    output incr_a, incr_b, clear_out, game_over, winner, score_a, score_b
  );
endinterface

// File: rtl/score_arbiter.sv
// score_arbiter: round-robin point arbiter with win detection and digit-chain clear sequencing
module score_arbiter #(
  parameter int WIN_SCORE = 21,
  parameter int SCORE_W   = 7
) (
  input logic          clk,
  input logic          reset,
  score_arbiter_if.slave bus
);
  typedef enum logic [1:0] {CLEAR, PLAY, OVER} state_t;
  state_t state;
  logic pt_a_d, pt_b_d, pending_a, pending_b, rr;
  logic incr_a, incr_b, clear_out, game_over, winner;
  logic [SCORE_W-1:0] score_a, score_b;
  logic edge_a, edge_b, grant_a, grant_b;
  logic [SCORE_W-1:0] next_a, next_b;
  assign edge_a  = bus.pt_a & ~pt_a_d;
  assign edge_b  = bus.pt_b & ~pt_b_d;
  // rr = 0 favours A when both are pending
  assign grant_a = pending_a & (~pending_b | ~rr);
  assign grant_b = pending_b & (~pending_a | rr);
  assign next_a  = score_a + 1'b1;
  assign next_b  = score_b + 1'b1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CLEAR;
      clear_out <= 1'b1;
      incr_a    <= 1'b0;
      incr_b    <= 1'b0;
      score_a   <= '0;
      score_b   <= '0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      pending_a <= 1'b0;
      pending_b <= 1'b0;
      rr        <= 1'b0;
      pt_a_d    <= 1'b0;
      pt_b_d    <= 1'b0;
    end else begin
      pt_a_d    <= bus.pt_a;
      pt_b_d    <= bus.pt_b;
      incr_a    <= 1'b0;
      incr_b    <= 1'b0;
      clear_out <= 1'b0;
      case (state)
        CLEAR: begin
          score_a   <= '0;
          score_b   <= '0;
          pending_a <= 1'b0;
          pending_b <= 1'b0;
          rr        <= 1'b0;
          state     <= PLAY;
        end
        PLAY: begin
          if (bus.new_game) begin
            state     <= CLEAR;
            clear_out <= 1'b1;
            game_over <= 1'b0;
            pending_a <= 1'b0;
            pending_b <= 1'b0;
          end else begin
            pending_a <= (pending_a & ~grant_a) | edge_a;
            pending_b <= (pending_b & ~grant_b) | edge_b;
            if (pending_a & pending_b) rr <= grant_a;
            if (grant_a) begin
              incr_a  <= 1'b1;
              score_a <= next_a;
            end
            if (grant_b) begin
              incr_b  <= 1'b1;
              score_b <= next_b;
            end
            // the winning grant still pulses; any queued opponent point is dropped
            if ((grant_a && next_a == SCORE_W'(WIN_SCORE)) || (grant_b && next_b == SCORE_W'(WIN_SCORE))) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= grant_b;
              pending_a <= 1'b0;
              pending_b <= 1'b0;
            end
          end
        end
        default: begin
          pending_a <= 1'b0;
          pending_b <= 1'b0;
          if (bus.new_game) begin
            state     <= CLEAR;
            clear_out <= 1'b1;
            game_over <= 1'b0;
          end
        end
      endcase
    end
  end
  assign bus.incr_a    = incr_a;
  assign bus.incr_b    = incr_b;
  assign bus.clear_out = clear_out;
  assign bus.score_a   = score_a;
  assign bus.score_b   = score_b;
  assign bus.game_over = game_over;
  assign bus.winner    = winner;
endmodule

// File: tb/tb_score_arbiter.sv
// tb_score_arbiter: directed checks of a WIN_SCORE=21 arbiter and a WIN_SCORE=3 arbiter sharing stimulus
module tb_score_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pt_a = 1'b0, pt_b = 1'b0, new_game = 1'b0;
  int tests = 0, fails = 0, cnt;
  always #5 clk = ~clk;
  score_arbiter_if #(.SCORE_W(7)) u_if ();
  score_arbiter_if #(.SCORE_W(7)) w_if ();
  assign u_if.pt_a = pt_a;
  assign u_if.pt_b = pt_b;
  assign u_if.new_game = new_game;
  assign w_if.pt_a = pt_a;
  assign w_if.pt_b = pt_b;
  assign w_if.new_game = new_game;
  score_arbiter #(.WIN_SCORE(21), .SCORE_W(7)) u_dut (.clk(clk), .reset(reset), .bus(u_if.slave));
  score_arbiter #(.WIN_SCORE(3),  .SCORE_W(7)) w_dut (.clk(clk), .reset(reset), .bus(w_if.slave));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_clear", u_if.clear_out, 1);
    chk("rst_incr", {u_if.incr_a, u_if.incr_b}, 0);
    chk("rst_scores", {u_if.score_a, u_if.score_b}, 0);
    chk("rst_over", {u_if.game_over, u_if.winner}, 0);
    reset = 1'b1;
    tick();
    chk("play_clear", u_if.clear_out, 0);
    chk("play_scores", {u_if.score_a, u_if.score_b}, 0);
    chk("play_over", u_if.game_over, 0);
    // single point for A
    pt_a = 1'b1;
    tick();
    chk("a1_lat", u_if.incr_a, 0);
    tick();
    chk("a1_incr", u_if.incr_a, 1);
    chk("a1_incr_b", u_if.incr_b, 0);
    chk("a1_score", u_if.score_a, 1);
    pt_a = 1'b0;
    tick();
    chk("a1_drop", u_if.incr_a, 0);
    // contested pair, rr starts at A
    pt_a = 1'b1; pt_b = 1'b1;
    tick();
    tick();
    chk("c1_a", {u_if.incr_a, u_if.incr_b}, 2'b10);
    pt_a = 1'b0; pt_b = 1'b0;
    tick();
    chk("c1_b", {u_if.incr_a, u_if.incr_b}, 2'b01);
    chk("c1_scores", {u_if.score_a, u_if.score_b}, {7'd2, 7'd1});
    tick();
    // second contested pair goes to B first
    pt_a = 1'b1; pt_b = 1'b1;
    tick();
    tick();
    chk("c2_b", {u_if.incr_a, u_if.incr_b}, 2'b01);
    pt_a = 1'b0; pt_b = 1'b0;
    tick();
    chk("c2_a", {u_if.incr_a, u_if.incr_b}, 2'b10);
    chk("c2_scores", {u_if.score_a, u_if.score_b}, {7'd3, 7'd2});
    tick();
    // held level gives one point
    cnt = 0;
    pt_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt += int'(u_if.incr_a);
    end
    pt_a = 1'b0;
    tick();
    cnt += int'(u_if.incr_a);
    chk("hold_pulses", cnt, 1);
    chk("hold_score", u_if.score_a, 4);
    // five edges two cycles apart
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      pt_a = 1'b1;
      tick();
      cnt += int'(u_if.incr_a);
      pt_a = 1'b0;
      tick();
      cnt += int'(u_if.incr_a);
    end
    tick();
    cnt += int'(u_if.incr_a);
    chk("tog_pulses", cnt, 5);
    chk("tog_score", u_if.score_a, 9);
    // new_game beats a pending grant
    pt_a = 1'b1;
    tick();
    new_game = 1'b1;
    tick();
    chk("ng_pri_incr", u_if.incr_a, 0);
    chk("ng_pri_score", u_if.score_a, 9);
    chk("ng_pri_clear", u_if.clear_out, 1);
    new_game = 1'b0; pt_a = 1'b0;
    tick();
    chk("ng_pri_zero", {u_if.score_a, u_if.score_b}, 0);
    // fresh game on the WIN_SCORE=3 instance
    reset = 1'b0;
    #1;
    chk("w_rst_clear", w_if.clear_out, 1);
    chk("w_rst_over", w_if.game_over, 0);
    reset = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      pt_a = 1'b1;
      tick();
      pt_a = 1'b0;
      tick();
    end
    chk("w_pre_score", w_if.score_a, 2);
    pt_a = 1'b1; pt_b = 1'b1;
    tick();
    tick();
    chk("win_incr", w_if.incr_a, 1);
    chk("win_score", w_if.score_a, 3);
    chk("win_over", w_if.game_over, 1);
    chk("win_who", w_if.winner, 0);
    chk("win_b", w_if.score_b, 0);
    pt_a = 1'b0; pt_b = 1'b0;
    tick();
    chk("win_b_drop", {w_if.incr_a, w_if.incr_b}, 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      pt_a = 1'b1; pt_b = 1'b1;
      tick();
      cnt += int'(w_if.incr_a) + int'(w_if.incr_b);
      pt_a = 1'b0; pt_b = 1'b0;
      tick();
      cnt += int'(w_if.incr_a) + int'(w_if.incr_b);
    end
    chk("over_pulses", cnt, 0);
    chk("over_scores", {w_if.score_a, w_if.score_b}, {7'd3, 7'd0});
    chk("over_hold", {w_if.game_over, w_if.winner}, 2'b10);
    // new game from OVER
    new_game = 1'b1;
    tick();
    chk("ng_clear", w_if.clear_out, 1);
    chk("ng_over", w_if.game_over, 0);
    new_game = 1'b0;
    tick();
    chk("ng_clear_end", w_if.clear_out, 0);
    chk("ng_scores", {w_if.score_a, w_if.score_b}, 0);
    // async reset in the middle of an incr_b pulse
    pt_b = 1'b1;
    tick();
    pt_b = 1'b0;
    tick();
    chk("mid_incr_b", w_if.incr_b, 1);
    chk("mid_score_b", w_if.score_b, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_incr", w_if.incr_b, 0);
    chk("mid_rst_clear", w_if.clear_out, 1);
    chk("mid_rst_score", w_if.score_b, 0);
    reset = 1'b1;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
